sequence_emitter: RTL and testbench
===================================

# sequence_emitter

Serial pattern transmitter that drives a single-bit tracked signal, such as the yellow line, with a programmed bit sequence. It feeds the sequence-detector FSMs in the traffic-light CDC/FPV environment. It accepts a pattern, length, repeat count and inter-repeat gap on a start request. It then shifts the pattern out MSB-of-field first, one bit per enabled cycle, and reports completion with a one-cycle done pulse.

## Interface
Parameters:
- MAX_LEN, 8, maximum pattern length in bits (>= 2)
- CNT_W, 4, width of the repeat and gap counters

Ports:
- clk  in  1  clock; all logic on the rising edge
- rst  in  1  reset, synchronous, active-high; overrides every other input
- en  in  1  advance enable; when 0, all state, counters and outputs hold
- start  in  1  request, sampled only in IDLE with en=1
- abort  in  1  cancel the transfer; sampled with en=1 in any non-IDLE state
- pattern  in  MAX_LEN  bits to send; bit len-1 is sent first and bit 0 last
- len  in  $clog2(MAX_LEN+1)  number of pattern bits; legal range 1..MAX_LEN
- repeat_n  in  CNT_W  number of repetitions; 0 = repeat continuously until abort
- gap  in  CNT_W  idle cycles between repetitions (tx_bit=0, tx_valid=0)
- tx_bit  out  1  serial data, registered; connects to the detector's tracked_signal
- tx_valid  out  1  high while tx_bit carries a pattern bit
- busy  out  1  high in SEND, GAP and DONE
- done  out  1  one-cycle pulse after the final bit of the final repetition
- err  out  1  one-cycle pulse when a start is rejected

## Operation
- States:
  - IDLE: outputs 0.
  - SEND: shifts bits.
  - GAP: counts idle cycles.
  - DONE: asserts done.
- IDLE:
  - start with len in 1..MAX_LEN: captures pattern, len, repeat_n and gap into internal registers, then goes to SEND.
  - start with len=0 or len>MAX_LEN: pulses err and stays in IDLE.
- Inputs are captured at acceptance. Changes to pattern, len, repeat_n or gap during busy have no effect.
- SEND:
  - Bit index starts at len-1 and decrements once per enabled cycle.
  - After index 0: if this is the last repetition, go to DONE. Otherwise go to GAP if gap>0, or start the next repetition in SEND at once if gap=0.
- GAP: holds for exactly gap enabled cycles, then returns to SEND with the index reloaded to len-1.
- Repetition counter:
  - Counts completed repetitions and saturates at its CNT_W-bit maximum.
  - When repeat_n=0, the last repetition is never reached.
- DONE: lasts one enabled cycle with done=1, then goes to IDLE.
- abort:
  - In SEND, GAP or DONE: next state is IDLE with all outputs 0.
  - done is not pulsed, unless it is already asserted in DONE.
- start while busy is ignored. No error is raised and nothing is queued.
- en=0 holds everything. A done or err pulse already asserted stays asserted until the next enabled cycle, so each pulse lasts exactly one enabled cycle.

## Timing
- Reset value of every output: tx_bit=0, tx_valid=0, busy=0, done=0, err=0. State after reset is IDLE.
- rst asserted mid-transfer: IDLE and all outputs 0 on the next cycle. The transfer is lost.
- start accepted at edge E0: busy=1, tx_valid=1 and tx_bit=pattern[len-1] are visible after E0.
- With en held at 1:
  - Bit k of a repetition is visible in the cycle after edge E0+k.
  - The full transfer spans N*len + (N-1)*gap cycles of busy SEND/GAP, followed by 1 DONE cycle.
  - busy drops the cycle after DONE.
  - The earliest new start is sampled in the first IDLE cycle.
- err asserts in the cycle after the rejected start edge.
- Simultaneous start and abort in IDLE: start wins, because abort is ignored in IDLE.
- repeat_n=0 with gap=0 produces a seamless periodic stream.

## Test plan
- pattern=8'b0000_0101, len=3, repeat_n=1, gap=0, en=1 -> tx_bit 1,0,1 with tx_valid=1 in cycles 1-3; done=1 in cycle 4; busy=1 in cycles 1-4 and 0 in cycle 5. A connected detector sees 101.
- Same pattern with repeat_n=2, gap=2 -> tx_bit/tx_valid sequence 1/1, 0/1, 1/1, 0/0, 0/0, 1/1, 0/1, 1/1; done in cycle 9.
- len=4, pattern=4'b1101, with en=0 for 3 cycles after the second bit -> tx_bit holds 1 for those cycles, then resumes 0,1. No bit is lost or repeated, and done is delayed by 3 cycles.
- start with len=0 -> err=1 for one cycle and busy stays 0. A second start issued while busy is ignored: the sequence is unchanged and err=0.
- repeat_n=0, gap=1, 16 cycles of continuous output, then abort -> the next cycle has tx_bit=0, tx_valid=0, busy=0, and done is never asserted.
- rst pulsed mid-SEND on bit 2 of 3 -> all outputs 0 on the next cycle. A fresh start then sends the full pattern from bit len-1.

Source files
------------

// File: rtl/sequence_emitter.sv
// sequence_emitter: serial pattern transmitter driving one tracked bit with a programmed sequence
// Ports: clk/rst (sync, active-high); i_en advance enable; i_start/i_abort requests;
//   i_pattern/i_len/i_repeat_n/i_gap transfer setup, captured when a start is accepted;
//   o_tx_bit/o_tx_valid serial data; o_busy in SEND/GAP/DONE; o_done/o_err one-cycle pulses.
module sequence_emitter #(
    parameter int MAX_LEN = 8,
    parameter int CNT_W   = 4
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         i_en,
    input  logic                         i_start,
    input  logic                         i_abort,
    input  logic [MAX_LEN-1:0]           i_pattern,
    input  logic [$clog2(MAX_LEN+1)-1:0] i_len,
    input  logic [CNT_W-1:0]             i_repeat_n,
    input  logic [CNT_W-1:0]             i_gap,
    output logic                         o_tx_bit,
    output logic                         o_tx_valid,
    output logic                         o_busy,
    output logic                         o_done,
    output logic                         o_err
);
    localparam int LW = $clog2(MAX_LEN + 1);
    localparam int IW = $clog2(MAX_LEN);
    localparam logic [LW-1:0] MAXL = LW'(MAX_LEN);
    typedef enum logic [1:0] {IDLE, SEND, GAP, DONE} state_t;
    state_t             r_state;
    logic [MAX_LEN-1:0] r_pat;
    logic [IW-1:0]      r_top;
    logic [IW-1:0]      r_idx;
    logic [CNT_W-1:0]   r_rep;
    logic [CNT_W-1:0]   r_gap;
    logic [CNT_W-1:0]   r_cnt;
    logic [CNT_W-1:0]   r_gcnt;
    logic               r_tx_bit;
    logic               r_tx_valid;
    logic               r_busy;
    logic               r_done;
    logic               r_err;
    logic               w_len_ok;
    logic               w_last;
    logic [IW-1:0]      w_in_top;
    logic [IW-1:0]      w_idx_m1;
    logic [CNT_W-1:0]   w_cnt_nx;
    assign w_len_ok = (i_len != '0) && (i_len <= MAXL);
    assign w_in_top = IW'(i_len - LW'(1));
    assign w_idx_m1 = r_idx - IW'(1);
    // r_cnt holds completed repetitions; the one in flight is last when r_cnt == r_rep-1
    assign w_last   = (r_rep != '0) && (r_cnt == r_rep - CNT_W'(1));
    assign w_cnt_nx = &r_cnt ? r_cnt : r_cnt + CNT_W'(1);
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= IDLE;
            r_pat      <= '0;
            r_top      <= '0;
            r_idx      <= '0;
            r_rep      <= '0;
            r_gap      <= '0;
            r_cnt      <= '0;
            r_gcnt     <= '0;
            r_tx_bit   <= 1'b0;
            r_tx_valid <= 1'b0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_err      <= 1'b0;
        end else if (i_en) begin
            r_done <= 1'b0;
            r_err  <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (i_start && w_len_ok) begin
                        r_state    <= SEND;
                        r_pat      <= i_pattern;
                        r_top      <= w_in_top;
                        r_idx      <= w_in_top;
                        r_rep      <= i_repeat_n;
                        r_gap      <= i_gap;
                        r_cnt      <= '0;
                        r_tx_bit   <= i_pattern[w_in_top];
                        r_tx_valid <= 1'b1;
                        r_busy     <= 1'b1;
                    end else if (i_start) begin
                        r_err <= 1'b1;
                    end
                end
                SEND: begin
                    if (i_abort) begin
                        r_state    <= IDLE;
                        r_tx_bit   <= 1'b0;
                        r_tx_valid <= 1'b0;
                        r_busy     <= 1'b0;
                    end else if (r_idx != '0) begin
                        r_idx    <= w_idx_m1;
                        r_tx_bit <= r_pat[w_idx_m1];
                    end else if (w_last) begin
                        r_state    <= DONE;
                        r_done     <= 1'b1;
                        r_tx_bit   <= 1'b0;
                        r_tx_valid <= 1'b0;
                    end else if (r_gap != '0) begin
                        r_state    <= GAP;
                        r_cnt      <= w_cnt_nx;
                        r_gcnt     <= r_gap;
                        r_tx_bit   <= 1'b0;
                        r_tx_valid <= 1'b0;
                    end else begin
                        r_cnt    <= w_cnt_nx;
                        r_idx    <= r_top;
                        r_tx_bit <= r_pat[r_top];
                    end
                end
                GAP: begin
                    if (i_abort) begin
                        r_state <= IDLE;
                        r_busy  <= 1'b0;
                    end else if (r_gcnt == CNT_W'(1)) begin
                        r_state    <= SEND;
                        r_idx      <= r_top;
                        r_tx_bit   <= r_pat[r_top];
                        r_tx_valid <= 1'b1;
                    end else begin
                        r_gcnt <= r_gcnt - CNT_W'(1);
                    end
                end
                default: begin
                    r_state <= IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end
    assign o_tx_bit   = r_tx_bit;
    assign o_tx_valid = r_tx_valid;
    assign o_busy     = r_busy;
    assign o_done     = r_done;
    assign o_err      = r_err;
endmodule

// File: tb/tb_sequence_emitter.sv
// tb_sequence_emitter: directed self-checking bench for sequence_emitter
module tb_sequence_emitter;
    localparam logic [4:0] S1 = 5'b11100;
    localparam logic [4:0] S0 = 5'b01100;
    localparam logic [4:0] GP = 5'b00100;
    localparam logic [4:0] DN = 5'b00110;
    localparam logic [4:0] ER = 5'b00001;
    localparam logic [4:0] ID = 5'b00000;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       en = 1'b1;
    logic       start = 1'b0;
    logic       abort = 1'b0;
    logic [7:0] pattern = '0;
    logic [3:0] len = '0;
    logic [3:0] repeat_n = '0;
    logic [3:0] gap = '0;
    logic       tx_bit, tx_valid, busy, done, err;
    logic [4:0] obs;
    logic [7:0] pv;
    int errors = 0;
    int checks = 0;
    assign obs = {tx_bit, tx_valid, busy, done, err};
    sequence_emitter #(.MAX_LEN(8), .CNT_W(4)) dut (
        .clk(clk), .rst(rst), .i_en(en), .i_start(start), .i_abort(abort),
        .i_pattern(pattern), .i_len(len), .i_repeat_n(repeat_n), .i_gap(gap),
        .o_tx_bit(tx_bit), .o_tx_valid(tx_valid), .o_busy(busy), .o_done(done), .o_err(err)
    );
    always #5 clk = ~clk;
    task automatic step();
        @(posedge clk);
        #1;
    endtask
    task automatic chk(input string tag, input logic [4:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask
    task automatic go(input logic [7:0] p, input logic [3:0] l, input logic [3:0] r, input logic [3:0] g);
        pattern = p; len = l; repeat_n = r; gap = g;
        start = 1'b1;
        step();
        start = 1'b0;
    endtask
    initial begin
        step(); step();
        chk("reset", ID);
        rst = 1'b0;
        step();
        chk("idle", ID);
        go(8'b0000_0101, 3, 1, 0);
        chk("t1_c1", S1); step();
        chk("t1_c2", S0); step();
        chk("t1_c3", S1); step();
        chk("t1_done", DN); step();
        chk("t1_idle", ID);
        go(8'b0000_0101, 3, 2, 2);
        pattern = 8'h00; len = 8; repeat_n = 0; gap = 0;
        chk("t2_c1", S1); step();
        chk("t2_c2", S0); step();
        chk("t2_c3", S1); step();
        chk("t2_gap1", GP); step();
        chk("t2_gap2", GP); step();
        chk("t2_c6", S1); step();
        chk("t2_c7", S0); step();
        chk("t2_c8", S1); step();
        chk("t2_done", DN); step();
        chk("t2_idle", ID);
        go(8'b0000_1101, 4, 1, 0);
        chk("t3_b3", S1); step();
        chk("t3_b2", S1);
        en = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("t3_hold", S1);
        end
        en = 1'b1;
        step(); chk("t3_b1", S0);
        step(); chk("t3_b0", S1);
        step(); chk("t3_done", DN);
        en = 1'b0;
        step(); chk("t3_done_hold", DN);
        en = 1'b1;
        step(); chk("t3_idle", ID);
        go(8'b0000_0101, 0, 1, 0);
        chk("t4_err_len0", ER); step();
        chk("t4_err_clear", ID);
        go(8'b0000_0101, 9, 1, 0);
        chk("t4_err_len9", ER); step();
        chk("t4_err_clear2", ID);
        go(8'b0000_0101, 3, 1, 0);
        chk("t4_c1", S1);
        pattern = 8'hFF; len = 0; start = 1'b1;
        step(); start = 1'b0;
        chk("t4_busy_start", S0); step();
        chk("t4_c3", S1); step();
        chk("t4_done", DN); step();
        chk("t4_idle", ID);
        go(8'b0000_0101, 3, 0, 1);
        for (int c = 0; c < 16; c++) begin
            chk("t5_cont", (c % 4 == 0) ? S1 : (c % 4 == 1) ? S0 : (c % 4 == 2) ? S1 : GP);
            if (c < 15) step();
        end
        abort = 1'b1;
        step();
        abort = 1'b0;
        chk("t5_abort", ID);
        for (int i = 0; i < 3; i++) begin
            step();
            chk("t5_no_done", ID);
        end
        go(8'b0000_0010, 2, 0, 0);
        for (int c = 0; c < 40; c++) begin
            chk("t5_seamless", (c % 2 == 0) ? S1 : S0);
            if (c < 39) step();
        end
        abort = 1'b1;
        step();
        abort = 1'b0;
        chk("t5_abort_send", ID);
        pattern = 8'b0000_0101; len = 3; repeat_n = 1; gap = 0;
        start = 1'b1; abort = 1'b1;
        step();
        start = 1'b0; abort = 1'b0;
        chk("t5_start_wins", S1);
        abort = 1'b1;
        step();
        abort = 1'b0;
        chk("t5_abort2", ID);
        go(8'b0000_0101, 3, 1, 0);
        chk("t6_c1", S1); step();
        chk("t6_c2", S0);
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("t6_rst", ID);
        go(8'b0000_0101, 3, 1, 0);
        chk("t6_c1b", S1); step();
        chk("t6_c2b", S0); step();
        chk("t6_c3b", S1); step();
        chk("t6_done", DN); step();
        chk("t6_idle", ID);
        pv = 8'b1011_0010;
        go(pv, 8, 1, 0);
        for (int k = 0; k < 8; k++) begin
            chk("t7_len8", {pv[7-k], 4'b1100});
            step();
        end
        chk("t7_done", DN); step();
        chk("t7_idle", ID);
        go(8'b0000_0001, 1, 2, 0);
        chk("t8_len1_r1", S1); step();
        chk("t8_len1_r2", S1); step();
        chk("t8_done", DN); step();
        chk("t8_idle", ID);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
